// File: rtl/conv_pe_array.sv
// conv_pe_array: NUM_PE parallel KxK filters accumulated over input channels, saturated ready/valid output
module conv_pe_array #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,
  parameter int NUM_PE    = 4,
  parameter int K         = 3,
  parameter int MAX_CH    = 4,
  parameter int SHIFT     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_start,
  input  logic [7:0]              cfg_num_ch,
  input  logic [15:0]             cfg_num_out,
  input  logic                    cfg_relu,
  input  logic                    w_vld,
  input  logic [WIDTH-1:0]        w_data,
  output logic                    w_rdy,
  input  logic                    act_vld,
  input  logic [K*K*WIDTH-1:0]    act_data,
  output logic                    act_rdy,
  output logic [NUM_PE*WIDTH-1:0] out_psum,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic                    busy,
  output logic                    done
);
  localparam int KK = K*K;
  localparam int CW = MAX_CH > 1 ? $clog2(MAX_CH) : 1;
  localparam int PW = NUM_PE > 1 ? $clog2(NUM_PE) : 1;
  localparam int KW = KK > 1 ? $clog2(KK) : 1;
  localparam int MW = 2*WIDTH;
  localparam logic [7:0] MAX_CH8 = 8'(MAX_CH);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
  state_t state, state_nx;

  logic [CW-1:0] c_last, wc, ch, ch0;
  logic [PW-1:0] wp;
  logic [KW-1:0] wk;
  logic [15:0] num_out, pix, ocnt;
  logic relu, en, w_fire, a_fire, o_fire, w_last, a_last, o_last;
  logic v0, v1, v2, v3, f0, f1, f2, l0, l1, l2, l3;
  logic [K*K*WIDTH-1:0] act_q;
  logic signed [WIDTH-1:0] wmem [MAX_CH][NUM_PE][KK];
  logic signed [MW-1:0] prod [NUM_PE][KK];
  logic signed [ACC_WIDTH-1:0] sum_d [NUM_PE];
  logic signed [ACC_WIDTH-1:0] sum_q [NUM_PE];
  logic signed [ACC_WIDTH-1:0] acc [NUM_PE];
  logic signed [ACC_WIDTH-1:0] shr [NUM_PE];
  logic signed [WIDTH-1:0] sat_d [NUM_PE];

  assign en     = !(out_vld && !out_rdy);
  assign w_fire = w_vld && w_rdy;
  assign a_fire = act_vld && act_rdy;
  assign o_fire = out_vld && out_rdy;
  assign w_last = wc == c_last && wp == PW'(NUM_PE-1) && wk == KW'(KK-1);
  assign a_last = ch == c_last && pix == num_out - 16'd1;
  assign o_last = ocnt == num_out - 16'd1;

  // Next-state and handshake outputs
  always_comb begin
    state_nx = state;
    w_rdy    = state == LOAD;
    act_rdy  = state == RUN && en;
    busy     = state != IDLE;
    case (state)
      IDLE:    state_nx = cfg_start ? LOAD : IDLE;
      LOAD:    if (w_fire && w_last) state_nx = num_out == '0 ? IDLE : RUN;
      RUN:     if (a_fire && a_last) state_nx = DRAIN;
      DRAIN:   if (o_fire && o_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register, config capture, weight/channel/pixel/output counters and done pulse
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      done    <= 1'b0;
      c_last  <= '0;
      num_out <= '0;
      relu    <= 1'b0;
      {wc, wp, wk, ch} <= '0;
      pix     <= '0;
      ocnt    <= '0;
    end else begin
      state <= state_nx;
      done  <= (state == LOAD && w_fire && w_last && num_out == '0) || (state == DRAIN && o_fire && o_last);
      if (state == IDLE && cfg_start) begin
        c_last  <= cfg_num_ch == 8'd0 ? '0 : cfg_num_ch > MAX_CH8 ? CW'(MAX_CH-1) : CW'(cfg_num_ch - 8'd1);
        num_out <= cfg_num_out;
        relu    <= cfg_relu;
        {wc, wp, wk, ch} <= '0;
        pix     <= '0;
        ocnt    <= '0;
      end
      if (w_fire) begin
        wk <= wk == KW'(KK-1) ? '0 : wk + KW'(1);
        if (wk == KW'(KK-1)) begin
          wp <= wp == PW'(NUM_PE-1) ? '0 : wp + PW'(1);
          if (wp == PW'(NUM_PE-1)) wc <= wc + CW'(1);
        end
      end
      if (a_fire) begin
        ch <= ch == c_last ? '0 : ch + CW'(1);
        if (ch == c_last) pix <= pix + 16'd1;
      end
      if (o_fire) ocnt <= ocnt + 16'd1;
    end

  // Weight store: word order is channel-major, then filter, then tap; kept across reset
  always_ff @(posedge clk)
    if (w_fire) wmem[wc][wp][wk] <= w_data;

  // Adder tree of one filter's tap products
  always_comb
    for (int p = 0; p < NUM_PE; p++) begin
      sum_d[p] = '0;
      for (int k = 0; k < KK; k++) sum_d[p] = sum_d[p] + ACC_WIDTH'(prod[p][k]);
    end

  // Output conditioning: arithmetic shift, optional ReLU, saturate to WIDTH
  always_comb
    for (int p = 0; p < NUM_PE; p++) begin
      shr[p]   = acc[p] >>> SHIFT;
      shr[p]   = relu && shr[p][ACC_WIDTH-1] ? '0 : shr[p];
      sat_d[p] = shr[p] > SAT_MAX ? WIDTH'(SAT_MAX) : shr[p] < SAT_MIN ? WIDTH'(SAT_MIN) : shr[p][WIDTH-1:0];
    end

  // Pipeline under one stall enable: capture, multiply, sum, accumulate, output register
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      {v0, f0, l0, v1, f1, l1, v2, f2, l2, v3, l3, out_vld} <= '0;
      ch0      <= '0;
      act_q    <= '0;
      prod     <= '{default: '0};
      sum_q    <= '{default: '0};
      acc      <= '{default: '0};
      out_psum <= '0;
    end else if (en) begin
      v0    <= a_fire;
      f0    <= ch == '0;
      l0    <= ch == c_last;
      ch0   <= ch;
      act_q <= act_data;
      v1    <= v0;
      f1    <= f0;
      l1    <= l0;
      for (int p = 0; p < NUM_PE; p++)
        for (int k = 0; k < KK; k++)
          prod[p][k] <= MW'(wmem[ch0][p][k]) * MW'($signed(act_q[k*WIDTH +: WIDTH]));
      v2    <= v1;
      f2    <= f1;
      l2    <= l1;
      sum_q <= sum_d;
      v3    <= v2;
      l3    <= l2;
      for (int p = 0; p < NUM_PE; p++)
        if (v2) acc[p] <= f2 ? sum_q[p] : acc[p] + sum_q[p];
      out_vld <= v3 && l3;
      if (v3 && l3)
        for (int p = 0; p < NUM_PE; p++) out_psum[p*WIDTH +: WIDTH] <= sat_d[p];
    end
endmodule

// File: doc/conv_pe_array.md
Name: conv_pe_array

Overview:
- Parametrised successor to the fixed 4-filter 3x3 computing core.
- Holds NUM_PE filters of KxK signed weights for up to MAX_CH input channels.
- Streams one KxK activation window per beat and accumulates each filter's result across input channels.
- Emits NUM_PE saturated WIDTH-bit outputs per output pixel over a ready/valid handshake; sits between the window buffer and the output writer.

Parameters:
WIDTH, 8, signed data/weight width
ACC_WIDTH, 24, signed accumulator width (must be >= 2*WIDTH + clog2(K*K*MAX_CH))
NUM_PE, 4, number of parallel filters
K, 3, kernel side (window holds K*K taps)
MAX_CH, 4, maximum input channels accumulated per output
SHIFT, 0, arithmetic right shift applied before saturation

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
cfg_start  in  1  start pulse; sampled only in IDLE
cfg_num_ch  in  8  input channels per output; sampled with cfg_start
cfg_num_out  in  16  output pixels to produce; sampled with cfg_start
cfg_relu  in  1  clamp negative results to 0; sampled with cfg_start
w_vld  in  1  weight word valid
w_data  in  WIDTH  weight word
w_rdy  out  1  weight accept (high only in LOAD)
act_vld  in  1  activation window valid
act_data  in  K*K*WIDTH  window; tap k at [k*WIDTH +: WIDTH], row-major
act_rdy  out  1  window accept
out_psum  out  NUM_PE*WIDTH  filter p result at [p*WIDTH +: WIDTH]
out_vld  out  1  output valid
out_rdy  in  1  output accept
busy  out  1  high when not IDLE
done  out  1  one-cycle pulse on return to IDLE

Behaviour:
- Reset (rst=0, async):
  - FSM to IDLE; all counters, accumulators and pipeline valids cleared.
  - Outputs: w_rdy, act_rdy, out_vld, busy, done = 0; out_psum = 0.
  - Weight storage is not cleared.
- Transfers occur on a rising edge with vld & rdy both high.
- Config sampling with cfg_start:
  - cfg_num_ch = 0 is treated as 1; values above MAX_CH clamp to MAX_CH. Let C be the effective value.
  - cfg_start while not IDLE is ignored.
- FSM:
  - IDLE -> LOAD on cfg_start.
  - LOAD: w_rdy = 1. Accepts exactly NUM_PE*K*K*C words. Word i maps to channel c, filter p, tap k with i = (c*NUM_PE + p)*K*K + k. The LOAD -> RUN transition happens on the edge that accepts the last word.
  - RUN: window beats carry channel c = 0..C-1 cyclically; the channel counter wraps to 0 after C-1. act_rdy = 1 unless the pipeline is stalled.
  - RUN -> DRAIN on acceptance of the last-channel window of pixel cfg_num_out.
  - If cfg_num_out = 0, LOAD -> IDLE directly with a done pulse.
  - DRAIN -> IDLE when the final output is accepted; done pulses in the cycle after that acceptance.
- Datapath pipeline (per PE, all stages share one enable):
  - Stage 1: K*K signed WIDTH x WIDTH products, registered.
  - Stage 2: adder tree sum, sign-extended to ACC_WIDTH, registered.
  - Stage 3: accumulator. For channel 0 it loads the sum; otherwise it adds the sum.
  - On the last channel, the accumulator value goes to the output register:
    - apply SHIFT as an arithmetic right shift;
    - if cfg_relu, clamp negatives to 0;
    - saturate to the signed range [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Latency: out_vld rises 4 cycles after the edge accepting the last-channel window, when unstalled.
- Stall: enable = !(out_vld & !out_rdy).
  - While stalled, act_rdy = 0 and every pipeline stage holds.
  - out_psum stays stable while out_vld is high and out_rdy is low.
- Throughput: 1 window per cycle; with out_rdy held high, outputs arrive one per C cycles.
- Simultaneous events: output acceptance and a new result on the same edge load the new result, with out_vld staying 1.
- Reset mid-RUN discards all partial sums; the next run requires a fresh LOAD.

Test Plan:
1. Reset then idle: rst low mid-RUN -> all outputs 0 next sample, busy=0; cfg_start during RUN ignored (counters unchanged).
2. Single channel, ones: load 36 weights = 1, C=1, cfg_num_out=2, windows all 2 -> out_psum each lane = 18, two outputs, done pulse after second acceptance.
3. Accumulation C=3: weights per channel c = c+1, windows all 1 -> each lane 9*(1+2+3)=54; out_vld exactly 4 cycles after the third window edge.
4. Saturation/ReLU: weights 127, windows 127 -> each lane 127; weights -128 with windows 127, cfg_relu=0 -> -128; same with cfg_relu=1 -> 0.
5. Backpressure: out_rdy low for 10 cycles with act_vld high -> act_rdy low during the stall, out_psum stable, no result lost; results match an unstalled run bit-for-bit.
6. Clamp/edge config: cfg_num_ch=0 -> 36 words loaded (C=1); cfg_num_ch=9 -> 144 words (C=4); cfg_num_out=0 -> done right after LOAD, no out_vld.
